// File: rtl/mem_stage_if.sv
// MEM stage boundary bundle: EX->MEM handshake, data-SRAM response, MEM->WB handshake, forwarding to ID.
// master = the MEM stage itself; slave = the surrounding pipeline/testbench.
// Signal names match the stage's documented port list.
interface mem_stage_if #(
  parameter int EXREG_BUS_LEN  = 75,
  parameter int MEMREG_BUS_LEN = 103
);
  logic                      EX_valid;
  logic [EXREG_BUS_LEN-1:0]  EXreg_bus;
  logic                      MEM_allow_in;
  logic                      data_sram_data_ok;
  logic [31:0]               data_sram_rdata;
  logic                      WB_allow_in;
  logic                      MEM_ready_go;
  logic                      valid;
  logic [MEMREG_BUS_LEN-1:0] MEMreg_bus;
  logic                      mem_fwd_we;
  logic [4:0]                mem_fwd_addr;
  logic [31:0]               mem_fwd_data;
  logic                      mem_fwd_stall;

  modport master (
    input  EX_valid, EXreg_bus, data_sram_data_ok, data_sram_rdata, WB_allow_in,
    output MEM_allow_in, MEM_ready_go, valid, MEMreg_bus,
           mem_fwd_we, mem_fwd_addr, mem_fwd_data, mem_fwd_stall
  );

  modport slave (
    output EX_valid, EXreg_bus, data_sram_data_ok, data_sram_rdata, WB_allow_in,
    input  MEM_allow_in, MEM_ready_go, valid, MEMreg_bus,
           mem_fwd_we, mem_fwd_addr, mem_fwd_data, mem_fwd_stall
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches EX bundle, waits for data-SRAM response, aligns/extends loads, registers result for WB.
// Latency: accept at edge N, data_ok in cycle N+k -> valid at edge N+k+1 (non-memory ops: 1 cycle).
// Backpressure: WB_allow_in=0 holds the output register; a response arriving then is kept in a one-entry skid buffer.
// Optional MEM_LOAD_FWD_EN: forward extracted load data to ID and stall only until the response arrives.
module mem_stage #(
  parameter int EXREG_BUS_LEN  = 75,
  parameter int MEMREG_BUS_LEN = 103
) (
  input  logic        clk,
  input  logic        resetn,
  mem_stage_if.master mem_if
);

  logic                      ms_valid;
  logic [EXREG_BUS_LEN-1:0]  ms_bus;
  logic                      buf_valid;
  logic [31:0]               buf_data;
  logic                      wb_valid;
  logic [MEMREG_BUS_LEN-1:0] wb_bus;

  // Fields of the held instruction, MSB first.
  logic        mem_req;
  logic [2:0]  mem_op;
  logic        res_from_mem;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] alu_result;
  logic [31:0] pc;

  assign {mem_req, mem_op, res_from_mem, rf_we, rf_waddr, alu_result, pc} = ms_bus;

  logic ready_go;
  logic allow_in;
  logic accept;
  logic leave;

  assign ready_go = !mem_req | mem_if.data_sram_data_ok | buf_valid;
  assign allow_in = !ms_valid | (ready_go & mem_if.WB_allow_in);
  assign accept   = mem_if.EX_valid & allow_in;
  assign leave    = ms_valid & ready_go & mem_if.WB_allow_in;

  logic [31:0] raw;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic [31:0] mem_result;

  // Pick the byte/half addressed by the low address bits and extend per mem_op.
  always_comb begin
    raw       = buf_valid ? buf_data : mem_if.data_sram_rdata;
    ld_byte   = raw[7:0];
    ld_half   = alu_result[1] ? raw[31:16] : raw[15:0];
    load_data = raw;
    case (alu_result[1:0])
      2'd1:    ld_byte = raw[15:8];
      2'd2:    ld_byte = raw[23:16];
      2'd3:    ld_byte = raw[31:24];
      default: ld_byte = raw[7:0];
    endcase
    case (mem_op)
      3'b001:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b010:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_data = {24'h0, ld_byte};
      3'b110:  load_data = {16'h0, ld_half};
      default: load_data = raw;
    endcase
  end

  // Stores and ALU ops carry no memory result.
  assign mem_result = res_from_mem ? load_data : 32'h0;

  // MEM stage register: accept from EX, or drain when the instruction moves to WB.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid <= 1'b0;
      ms_bus   <= '0;
    end else if (accept) begin
      ms_valid <= 1'b1;
      ms_bus   <= mem_if.EXreg_bus;
    end else if (ready_go & mem_if.WB_allow_in) begin
      ms_valid <= 1'b0;
    end
  end

  // Skid buffer: keep the one-cycle rdata when WB is not ready to take the result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_valid <= 1'b0;
      buf_data  <= 32'h0;
    end else if (leave) begin
      buf_valid <= 1'b0;
    end else if (ms_valid & mem_req & mem_if.data_sram_data_ok & !mem_if.WB_allow_in & !buf_valid) begin
      buf_valid <= 1'b1;
      buf_data  <= mem_if.data_sram_rdata;
    end
  end

  // Output register toward WB; frozen while WB stalls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wb_valid <= 1'b0;
      wb_bus   <= '0;
    end else if (mem_if.WB_allow_in) begin
      wb_valid <= ms_valid & ready_go;
      if (ms_valid & ready_go) begin
        wb_bus <= {alu_result, mem_result, rf_we, res_from_mem, rf_waddr, pc};
      end
    end
  end

  assign mem_if.MEM_allow_in = allow_in;
  assign mem_if.MEM_ready_go = ready_go;
  assign mem_if.valid        = wb_valid;
  assign mem_if.MEMreg_bus   = wb_bus;

  // r0 is never a real destination, so it never forwards.
  assign mem_if.mem_fwd_we   = ms_valid & rf_we & (rf_waddr != 5'd0);
  assign mem_if.mem_fwd_addr = rf_waddr;

`ifdef MEM_LOAD_FWD_EN
  assign mem_if.mem_fwd_data  = res_from_mem ? load_data : alu_result;
  assign mem_if.mem_fwd_stall = mem_if.mem_fwd_we & res_from_mem & !ready_go;
`else
  assign mem_if.mem_fwd_data  = alu_result;
  assign mem_if.mem_fwd_stall = mem_if.mem_fwd_we & res_from_mem;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage with a transaction-level reference model and in-order pc scoreboard.
// Directed sequences first (ALU, loads, skid, back-to-back, forwarding, async reset), then random traffic.
module tb_mem_stage;

  typedef struct packed {
    logic        mem_req;
    logic [2:0]  op;
    logic        rfm;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] alu;
    logic [31:0] pc;
  } ins_t;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  mem_stage_if bus_if ();

  mem_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .mem_if (bus_if)
  );

  always #5 clk = ~clk;

  // Reference model state: the instruction sitting in MEM, whether its response
  // has arrived (and the data), and what WB currently sees.
  logic          m_v;
  ins_t          m_ins;
  logic          m_have;
  logic [31:0]   m_rd;
  logic          o_v;
  logic [102:0]  o_bus;
  logic [31:0]   exp_q[$];
  logic [31:0]   pc_ctr;
  ins_t          nop;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] load_value(input logic [2:0] op, input logic [1:0] a, input logic [31:0] raw);
    logic [31:0] b;
    logic [31:0] h;
    b = (raw >> (8 * a)) & 32'hFF;
    h = (raw >> (16 * a[1])) & 32'hFFFF;
    case (op)
      3'b001:  return (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
      3'b010:  return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
      3'b101:  return b;
      3'b110:  return h;
      default: return raw;
    endcase
  endfunction

  task automatic model_reset();
    m_v    = 1'b0;
    m_ins  = '0;
    m_have = 1'b0;
    m_rd   = 32'h0;
    o_v    = 1'b0;
    o_bus  = '0;
    exp_q.delete();
  endtask

  // One clock cycle: drive at negedge, compare combinational/registered outputs, advance model at posedge.
  task automatic cycle(input logic ex_v, input ins_t ins, input logic dok, input logic [31:0] rd, input logic wb);
    logic        done;
    logic        allow_m;
    logic        fwd_we_m;
    logic        stall_m;
    logic [31:0] raw;
    logic [31:0] res;
    logic [31:0] fwd_d;
    logic [31:0] seen_pc;
    logic [31:0] want_pc;
    @(negedge clk);
    bus_if.EX_valid          = ex_v;
    bus_if.EXreg_bus         = ins;
    bus_if.data_sram_data_ok = dok;
    bus_if.data_sram_rdata   = rd;
    bus_if.WB_allow_in       = wb;
    #1;
    done     = m_v && (!m_ins.mem_req || dok || m_have);
    allow_m  = !m_v || (done && wb);
    raw      = m_have ? m_rd : rd;
    res      = load_value(m_ins.op, m_ins.alu[1:0], raw);
    fwd_we_m = m_v && m_ins.rf_we && (m_ins.waddr != 5'd0);
`ifdef MEM_LOAD_FWD_EN
    stall_m  = fwd_we_m && m_ins.rfm && !done;
    fwd_d    = m_ins.rfm ? res : m_ins.alu;
`else
    stall_m  = fwd_we_m && m_ins.rfm;
    fwd_d    = m_ins.alu;
`endif
    check("valid", bus_if.valid, o_v);
    check("memreg_bus", bus_if.MEMreg_bus, o_bus);
    check("allow_in", bus_if.MEM_allow_in, allow_m);
    check("fwd_we", bus_if.mem_fwd_we, fwd_we_m);
    check("fwd_stall", bus_if.mem_fwd_stall, stall_m);
    if (m_v) begin
      check("ready_go", bus_if.MEM_ready_go, done);
      check("fwd_data", bus_if.mem_fwd_data, fwd_d);
    end
    if (fwd_we_m) check("fwd_addr", bus_if.mem_fwd_addr, m_ins.waddr);
    seen_pc = bus_if.MEMreg_bus[31:0];
    @(posedge clk);
    if (o_v && wb && exp_q.size() != 0) begin
      want_pc = exp_q.pop_front();
      check("order_pc", seen_pc, want_pc);
    end
    if (wb) begin
      o_v = done;
      if (done) o_bus = {m_ins.alu, (m_ins.rfm ? res : 32'h0), m_ins.rf_we, m_ins.rfm, m_ins.waddr, m_ins.pc};
    end
    if (done && wb) begin
      m_v    = 1'b0;
      m_have = 1'b0;
    end else if (m_v && m_ins.mem_req && dok && !m_have) begin
      m_have = 1'b1;
      m_rd   = rd;
    end
    if (ex_v && allow_m) begin
      m_v    = 1'b1;
      m_ins  = ins;
      m_have = 1'b0;
      exp_q.push_back(ins.pc);
    end
  endtask

  function automatic ins_t mk(input logic mr, input logic [2:0] op, input logic rfm, input logic we,
                              input logic [4:0] wa, input logic [31:0] alu, input logic [31:0] pc);
    ins_t i;
    i = {mr, op, rfm, we, wa, alu, pc};
    return i;
  endfunction

  function automatic ins_t rand_ins(input logic [31:0] pc);
    ins_t i;
    i.mem_req = 1'($urandom_range(0, 1));
    i.op      = 3'($urandom_range(0, 7));
    if (i.mem_req) begin
      if ($urandom_range(0, 3) != 0) begin
        i.rfm   = 1'b1;
        i.rf_we = 1'b1;
        case ($urandom_range(0, 5))
          0: i.op = 3'b000;
          1: i.op = 3'b001;
          2: i.op = 3'b010;
          3: i.op = 3'b101;
          4: i.op = 3'b110;
          default: i.op = 3'($urandom_range(0, 7));
        endcase
      end else begin
        i.rfm   = 1'b0;
        i.rf_we = 1'b0;
      end
    end else begin
      i.rfm   = 1'b0;
      i.rf_we = 1'($urandom_range(0, 1));
    end
    i.waddr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    i.alu   = $urandom;
    i.pc    = pc;
    return i;
  endfunction

  initial begin
    ins_t a;
    ins_t l;
    logic dok;
    checks   = 0;
    failures = 0;
    clk      = 1'b0;
    resetn   = 1'b0;
    nop      = '0;
    pc_ctr   = 32'h1c001000;
    bus_if.EX_valid          = 1'b0;
    bus_if.EXreg_bus         = '0;
    bus_if.data_sram_data_ok = 1'b0;
    bus_if.data_sram_rdata   = 32'h0;
    bus_if.WB_allow_in       = 1'b1;
    model_reset();

    // Reset state
    #3;
    check("rst_valid", bus_if.valid, 1'b0);
    check("rst_bus", bus_if.MEMreg_bus, 103'h0);
    check("rst_allow", bus_if.MEM_allow_in, 1'b1);
    check("rst_fwd_we", bus_if.mem_fwd_we, 1'b0);
    check("rst_stall", bus_if.mem_fwd_stall, 1'b0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Single ALU op
    a = mk(1'b0, 3'b000, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h1c000000);
    cycle(1'b1, a, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, nop, 1'b0, 32'h0, 1'b1);
    #2;
    check("alu_valid", bus_if.valid, 1'b1);
    check("alu_bus", bus_if.MEMreg_bus, {32'h1234, 32'h0, 1'b1, 1'b0, 5'd5, 32'h1c000000});

    // ld.b and ld.bu with data_ok two cycles after accept
    l = mk(1'b1, 3'b001, 1'b1, 1'b1, 5'd3, 32'h1c002002, 32'h1c000010);
    cycle(1'b1, l, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, nop, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, nop, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, nop, 1'b1, 32'h00AB0000, 1'b1);
    #2;
    check("ldb_valid", bus_if.valid, 1'b1);
    check("ldb_result", bus_if.MEMreg_bus[70:39], 32'hFFFFFFAB);
    l.op = 3'b101;
    l.pc = 32'h1c000014;
    cycle(1'b1, l, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, nop, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, nop, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, nop, 1'b1, 32'h00AB0000, 1'b1);
    #2;
    check("ldbu_result", bus_if.MEMreg_bus[70:39], 32'h000000AB);

    // ld.hu with WB stalled in the data_ok cycle: value parked in the skid buffer
    l = mk(1'b1, 3'b110, 1'b1, 1'b1, 5'd9, 32'h1c003002, 32'h1c000018);
    cycle(1'b1, l, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, nop, 1'b1, 32'h80011234, 1'b0);
    #2;
    check("skid_buf", dut.buf_valid, 1'b1);
    cycle(1'b0, nop, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, nop, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, nop, 1'b0, 32'hFFFFFFFF, 1'b1);
    #2;
    check("skid_valid", bus_if.valid, 1'b1);
    check("skid_result", bus_if.MEMreg_bus[70:39], 32'h00008001);

    // Three back-to-back ALU ops
    for (int k = 0; k < 3; k++) begin
      a = mk(1'b0, 3'b000, 1'b0, 1'b1, 5'(k + 10), 32'(k * 16), 32'h1c000100 + 32'(k * 4));
      cycle(1'b1, a, 1'b0, 32'h0, 1'b1);
    end
    cycle(1'b0, nop, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, nop, 1'b0, 32'h0, 1'b1);

    // Forwarding: load to r7 waiting on data_ok, then a write to r0
    l = mk(1'b1, 3'b000, 1'b1, 1'b1, 5'd7, 32'h1c004000, 32'h1c000200);
    cycle(1'b1, l, 1'b0, 32'h0, 1'b1);
    #2;
    check("fwd_r7_we", bus_if.mem_fwd_we, 1'b1);
    check("fwd_r7_addr", bus_if.mem_fwd_addr, 5'd7);
    cycle(1'b0, nop, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, nop, 1'b1, 32'hCAFE0001, 1'b1);
    a = mk(1'b0, 3'b000, 1'b0, 1'b1, 5'd0, 32'h55, 32'h1c000204);
    cycle(1'b1, a, 1'b0, 32'h0, 1'b1);
    #2;
    check("fwd_r0_we", bus_if.mem_fwd_we, 1'b0);
    cycle(1'b0, nop, 1'b0, 32'h0, 1'b1);

    // Asynchronous reset while a load holds buffered data and WB holds a result
    a = mk(1'b0, 3'b000, 1'b0, 1'b1, 5'd4, 32'h77, 32'h1c000300);
    l = mk(1'b1, 3'b000, 1'b1, 1'b1, 5'd8, 32'h1c005000, 32'h1c000304);
    cycle(1'b1, a, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, l, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, nop, 1'b1, 32'h12345678, 1'b0);
    #3;
    check("pre_rst_valid", bus_if.valid, 1'b1);
    resetn = 1'b0;
    #1;
    check("arst_valid", bus_if.valid, 1'b0);
    check("arst_ms_valid", dut.ms_valid, 1'b0);
    check("arst_buf_valid", dut.buf_valid, 1'b0);
    check("arst_allow", bus_if.MEM_allow_in, 1'b1);
    check("arst_fwd_we", bus_if.mem_fwd_we, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    cycle(1'b0, nop, 1'b1, 32'hDEAD0000, 1'b1);
    #2;
    check("late_dok_valid", bus_if.valid, 1'b0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      a = rand_ins(pc_ctr);
      if (m_v && m_ins.mem_req && !m_have)
        dok = ($urandom_range(0, 2) == 0);
      else if (!m_v)
        dok = ($urandom_range(0, 7) == 0);
      else
        dok = 1'b0;
      cycle(($urandom_range(0, 9) < 6), a, dok, $urandom, ($urandom_range(0, 9) < 7));
      pc_ctr = pc_ctr + 32'd4;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
